// File: rtl/rv32i_stage_ctrl.sv
// rv32i_stage_ctrl: multi-cycle stage sequencer for the unpipelined RV32I core.
// Steps FETCH -> DECODE -> EXECUTE -> MEMORYACCESS -> WRITEBACK, handshakes
// with the instruction/data memories, watches for bus timeouts, honours
// stall/flush and drives the ALU operands.
// Optional build macro: SKIP_MEMSTAGE_EN lets non load/store instructions
// bypass MEMORYACCESS, which saves one cycle on those instructions.
module rv32i_stage_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     inst,
    input  logic            inst_ack,
    output logic            inst_req,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            opcode_jal,
    input  logic            opcode_auipc,
    input  logic            opcode_rtype,
    input  logic            opcode_branch,
    input  logic            opcode_load,
    input  logic            opcode_store,
    input  logic            dmem_ack,
    output logic            dmem_req,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [31:0]     inst_q,
    output logic [2:0]      stage_q,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic            alu_stage,
    output logic            memoryaccess_stage,
    output logic            writeback_stage,
    output logic            retire,
    output logic            bus_fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_DEC   = 3'd1;
    localparam logic [2:0] ST_EXE   = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;

    logic [2:0]    r_stage;
    logic [31:0]   r_inst;
    logic [CW-1:0] r_cnt;
    logic          r_fault;

    logic [2:0]    w_stage_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_inst_ld;
    logic          w_fault_nxt;
    logic          w_memop;
    logic          w_req;
    logic          w_ack;
    logic          w_wait;
    logic          w_timeout;

    assign w_memop   = opcode_load | opcode_store;
    // A request cycle is any FETCH cycle or a load/store MEMORYACCESS cycle.
    assign w_req     = (r_stage == ST_FETCH) | ((r_stage == ST_MEM) & w_memop);
    assign w_ack     = (r_stage == ST_FETCH) ? inst_ack : dmem_ack;
    assign w_wait    = w_req & ~w_ack;
    assign w_timeout = w_wait & (r_cnt == CW'(TIMEOUT));

    assign stage_q   = r_stage;
    assign inst_q    = r_inst;
    assign bus_fault = r_fault;

    // State register: stage, latched instruction, wait counter, fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= ST_FETCH;
            r_inst  <= 32'd0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_stage <= w_stage_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= w_fault_nxt;
            if (w_inst_ld) begin
                r_inst <= inst;
            end else begin
                r_inst <= r_inst;
            end
        end
    end

    // Next-state logic: flush beats timeout, timeout beats handshake/stall.
    always_comb begin
        w_stage_nxt = r_stage;
        w_inst_ld   = 1'b0;
        w_fault_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        if (flush_i) begin
            w_stage_nxt = ST_FETCH;
            w_cnt_nxt   = '0;
        end else if (w_timeout) begin
            w_stage_nxt = ST_FETCH;
            w_cnt_nxt   = '0;
            w_fault_nxt = 1'b1;
        end else begin
            case (r_stage)
                ST_FETCH: begin
                    if (inst_ack) begin
                        w_stage_nxt = ST_DEC;
                        w_inst_ld   = 1'b1;
                    end else begin
                        w_stage_nxt = ST_FETCH;
                    end
                end
                ST_DEC: begin
                    w_stage_nxt = stall_i ? ST_DEC : ST_EXE;
                end
                ST_EXE: begin
                    if (stall_i) begin
                        w_stage_nxt = ST_EXE;
                    end else begin
`ifdef SKIP_MEMSTAGE_EN
                        w_stage_nxt = w_memop ? ST_MEM : ST_WB;
`else
                        w_stage_nxt = ST_MEM;
`endif
                    end
                end
                ST_MEM: begin
                    if (w_memop && !dmem_ack) begin
                        w_stage_nxt = ST_MEM;
                    end else begin
                        w_stage_nxt = ST_WB;
                    end
                end
                ST_WB: begin
                    w_stage_nxt = stall_i ? ST_WB : ST_FETCH;
                end
                default: begin
                    w_stage_nxt = ST_FETCH;
                end
            endcase
            // Counter restarts on every stage change and counts unacked request cycles.
            if (w_stage_nxt != r_stage) begin
                w_cnt_nxt = '0;
            end else if (w_wait) begin
                w_cnt_nxt = r_cnt + CW'(1);
            end else begin
                w_cnt_nxt = r_cnt;
            end
        end
    end

    // Output decode: requests, stage flags, retire and ALU operand muxing.
    always_comb begin
        inst_req           = (r_stage == ST_FETCH);
        dmem_req           = (r_stage == ST_MEM) & w_memop;
        alu_stage          = (r_stage == ST_EXE);
        memoryaccess_stage = (r_stage == ST_MEM);
        writeback_stage    = (r_stage == ST_WB);
        retire             = (r_stage == ST_WB) & ~stall_i & ~flush_i;
        if (r_stage == ST_EXE) begin
            a = (opcode_jal | opcode_auipc) ? pc : rs1;
            b = (opcode_rtype | opcode_branch) ? rs2 : imm;
        end else begin
            a = '0;
            b = '0;
        end
    end

endmodule

// File: doc/rv32i_stage_ctrl.md
# rv32i_stage_ctrl

Parametrised multi-cycle control FSM for the unpipelined RV32I core. It sequences FETCH, DECODE, EXECUTE, MEMORYACCESS and WRITEBACK, and drives the ALU operands. Unlike a fixed-latency sequencer, it handshakes with the instruction and data memories (req/ack with wait states) and enforces a bus timeout. It also accepts an external stall and a trap flush, and reports retirement. It sits between the decoder/register file and the ALU/memory/writeback logic.

## Interface
- XLEN, 32, datapath width for pc, rs1, rs2, imm, a, b
- TIMEOUT, 15, maximum number of unacknowledged request cycles before a bus fault (≥1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inst  in  32  instruction read data, valid when inst_ack
- inst_ack  in  1  instruction memory acknowledge
- inst_req  out  1  instruction fetch request
- pc, rs1, rs2, imm  in  XLEN  operand sources
- opcode_jal, opcode_auipc, opcode_rtype, opcode_branch, opcode_load, opcode_store  in  1 each  decoded opcode class of inst_q
- dmem_ack  in  1  data memory acknowledge
- dmem_req  out  1  data memory request
- stall_i  in  1  hold request from execution units
- flush_i  in  1  trap/redirect; abandon current instruction
- inst_q  out  32  registered instruction
- stage_q  out  3  current stage (FETCH=0, DECODE=1, EXECUTE=2, MEMORYACCESS=3, WRITEBACK=4)
- a, b  out  XLEN  ALU operands
- alu_stage, memoryaccess_stage, writeback_stage  out  1 each  stage decodes
- retire  out  1  instruction completes this cycle
- bus_fault  out  1  one-cycle registered pulse on timeout

## Operation
- Reset: stage_q=FETCH, inst_q=0, wait counter=0, bus_fault=0. All combinational outputs follow from these values.
- Next-state priority: flush_i, then timeout, then handshake/stall.
- FETCH: inst_req=1.
  - On inst_ack: inst_q←inst, go to DECODE.
  - Otherwise stay in FETCH and increment the counter.
- DECODE: go to EXECUTE unless stall_i.
- EXECUTE:
  - a = pc if (opcode_jal|opcode_auipc), else rs1.
  - b = rs2 if (opcode_rtype|opcode_branch), else imm.
  - Go to MEMORYACCESS unless stall_i.
  - a=b=0 in all other stages.
- MEMORYACCESS:
  - Load/store: dmem_req=1; on dmem_ack go to WRITEBACK, otherwise increment the counter.
  - Other instructions: dmem_req=0; go to WRITEBACK next cycle.
- WRITEBACK:
  - retire = writeback_stage & ~stall_i & ~flush_i.
  - Go to FETCH unless stall_i.
- stall_i handling: ignored in FETCH and MEMORYACCESS, because bus handshakes are not stallable. Holds stage_q and inst_q elsewhere.
- Wait counter:
  - Width $clog2(TIMEOUT+1).
  - Cleared on every stage transition and on flush.
  - If counter==TIMEOUT and no ack in a request cycle: bus_fault←1 next cycle, stage←FETCH, counter←0, inst_q held, no retire.
- flush_i:
  - Next stage FETCH, counter cleared, inst_q held, no retire, no fault.
  - A coincident inst_ack or dmem_ack is discarded.
- Illegal stage_q encodings (5–7) go to FETCH.

## Timing
- Zero-wait memories (ack in the same cycle as req): exactly 5 cycles per instruction, with retire in the 5th.
- Each wait cycle adds 1. A request is asserted for at most TIMEOUT+1 cycles, and an ack on cycle TIMEOUT+1 is accepted.
- inst_req and dmem_req are combinational from stage_q and opcode only. They drop the cycle after ack, flush or fault.
- bus_fault is high for exactly one cycle, during the first FETCH cycle after the fault.
- Asserting rst_n mid-handshake aborts immediately; requests deassert asynchronously with reset.

## Configuration
- SKIP_MEMSTAGE_EN
  - Defined: EXECUTE goes directly to WRITEBACK when neither opcode_load nor opcode_store is set, giving a 4-cycle non-memory instruction. memoryaccess_stage is never high for those instructions.
  - Undefined: every instruction passes through MEMORYACCESS (5-cycle minimum).

## Test plan
- Zero-wait ADD (rtype), acks tied high → stage sequence 0,1,2,3,4,0, retire high only in cycle 5, a=rs1, b=rs2 in EXECUTE.
- JAL with inst_ack after 3 wait cycles → inst_req high 4 cycles, inst_q latched on the ack edge, a=pc, b=imm, retire in cycle 8.
- LW with dmem_ack never asserted, TIMEOUT=15 → dmem_req high 16 cycles, bus_fault pulse 1 cycle, stage_q=0, no retire. A repeat test with ack on the 16th cycle must succeed.
- stall_i high 3 cycles in EXECUTE → stage_q stays 2 for 4 cycles, a/b stable. stall_i during FETCH wait → no effect.
- flush_i coincident with inst_ack in FETCH, then flush_i in MEMORYACCESS of a SW → inst_q unchanged, next stage 0, no retire/fault, dmem_req drops next cycle.
- With SKIP_MEMSTAGE_EN, ADDI → stages 0,1,2,4,0 (4 cycles); LW → still 5 cycles. rst_n pulsed mid-FETCH-wait → stage_q=0, inst_q=0, bus_fault=0 immediately.
